// File: rtl/calc_mem_responder_if.sv
// Request/response bundle between the calculator controller and its memory responder.
interface calc_mem_responder_if #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned MEM_WORD_SIZE = 64,
  parameter int unsigned CNT_W         = 16
);
  logic                     read;
  logic [ADDR_W-1:0]        r_addr;
  logic [MEM_WORD_SIZE-1:0] r_data;
  logic                     r_valid;
  logic                     write;
  logic [ADDR_W-1:0]        w_addr;
  logic [MEM_WORD_SIZE-1:0] w_data;
  logic                     busy;
  logic                     req_dropped;
  logic                     addr_err;
  logic [CNT_W-1:0]         rd_count;
  logic [CNT_W-1:0]         wr_count;

  modport master (
    output read, r_addr, write, w_addr, w_data,
    input  r_data, r_valid, busy, req_dropped, addr_err, rd_count, wr_count
  );

  modport slave (
    input  read, r_addr, write, w_addr, w_data,
    output r_data, r_valid, busy, req_dropped, addr_err, rd_count, wr_count
  );
endinterface

// File: rtl/calc_mem_responder.sv
// Word-array responder: 1-cycle registered reads, same-edge writes, post-reset
// zeroing sweep, sticky range error and saturating access counters.
module calc_mem_responder #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned MEM_WORD_SIZE = 64,
  parameter int unsigned MEM_DEPTH     = 200,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  calc_mem_responder_if.slave   bus
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        clr_ptr_q, clr_ptr_d;
  logic [MEM_WORD_SIZE-1:0] r_data_q, r_data_d;
  logic                     r_valid_q, r_valid_d;
  logic                     req_dropped_q, req_dropped_d;
  logic                     addr_err_q, addr_err_d;
  logic [CNT_W-1:0]         rd_count_q, rd_count_d;
  logic [CNT_W-1:0]         wr_count_q, wr_count_d;

  logic                     mem_we_c;
  logic [IDX_W-1:0]         mem_idx_c;
  logic [MEM_WORD_SIZE-1:0] mem_wdata_c;
  logic                     rd_oob_c, wr_oob_c;

  logic [MEM_WORD_SIZE-1:0] mem_q [MEM_DEPTH];

  assign rd_oob_c = 32'(bus.r_addr) >= MEM_DEPTH;
  assign wr_oob_c = 32'(bus.w_addr) >= MEM_DEPTH;

  // Next-state, write-port and response logic
  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    r_data_d      = r_data_q;
    r_valid_d     = 1'b0;
    req_dropped_d = 1'b0;
    addr_err_d    = addr_err_q;
    rd_count_d    = rd_count_q;
    wr_count_d    = wr_count_q;
    mem_we_c      = 1'b0;
    mem_idx_c     = '0;
    mem_wdata_c   = '0;

    unique case (state_q)
      S_CLEAR: begin
        mem_we_c      = 1'b1;
        mem_idx_c     = IDX_W'(clr_ptr_q);
        clr_ptr_d     = clr_ptr_q + ADDR_W'(1);
        req_dropped_d = bus.read | bus.write;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        // Read samples the array before this edge's write: read-before-write
        if (bus.read) begin
          r_valid_d = 1'b1;
          r_data_d  = rd_oob_c ? '0 : mem_q[IDX_W'(bus.r_addr)];
          if (rd_count_q != CNT_MAX) rd_count_d = rd_count_q + CNT_W'(1);
          if (rd_oob_c) addr_err_d = 1'b1;
        end
        if (bus.write) begin
          if (wr_count_q != CNT_MAX) wr_count_d = wr_count_q + CNT_W'(1);
          if (wr_oob_c) begin
            addr_err_d = 1'b1;
          end else begin
            mem_we_c    = 1'b1;
            mem_idx_c   = IDX_W'(bus.w_addr);
            mem_wdata_c = bus.w_data;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_CLEAR;
      clr_ptr_q     <= '0;
      r_data_q      <= '0;
      r_valid_q     <= 1'b0;
      req_dropped_q <= 1'b0;
      addr_err_q    <= 1'b0;
      rd_count_q    <= '0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      r_data_q      <= r_data_d;
      r_valid_q     <= r_valid_d;
      req_dropped_q <= req_dropped_d;
      addr_err_q    <= addr_err_d;
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // Array storage is not reset; the sweep zeroes it
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_we_c) begin
      mem_q[mem_idx_c] <= mem_wdata_c;
    end
  end

  assign bus.busy        = (state_q == S_CLEAR);
  assign bus.r_data      = r_data_q;
  assign bus.r_valid     = r_valid_q;
  assign bus.req_dropped = req_dropped_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.rd_count    = rd_count_q;
  assign bus.wr_count    = wr_count_q;

endmodule

// File: tb/tb_calc_mem_responder.sv
// Directed self-checking bench for calc_mem_responder.
module tb_calc_mem_responder;

  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned MEM_WORD_SIZE = 64;
  localparam int unsigned MEM_DEPTH     = 200;
  localparam int unsigned CNT_W         = 16;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  calc_mem_responder_if #(
    .ADDR_W(ADDR_W), .MEM_WORD_SIZE(MEM_WORD_SIZE), .CNT_W(CNT_W)
  ) u_if ();

  calc_mem_responder #(
    .ADDR_W(ADDR_W), .MEM_WORD_SIZE(MEM_WORD_SIZE),
    .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (u_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    u_if.read   = 1'b0;
    u_if.write  = 1'b0;
    u_if.r_addr = '0;
    u_if.w_addr = '0;
    u_if.w_data = '0;
  endtask

  // Releases reset, then counts busy cycles until the sweep ends
  task automatic release_and_sweep(output int cnt);
    rst_ni = 1'b1;
    cnt = 0;
    while (u_if.busy === 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_reset();
    int cnt;
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    release_and_sweep(cnt);
    checks++;
    if (cnt != 200) begin
      errors++;
      $display("FAIL sweep_len: got %0d cycles, expected 200", cnt);
    end
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    checks++;
    if (u_if.busy !== 1'b1 || u_if.r_valid !== 1'b0 || u_if.req_dropped !== 1'b0 ||
        u_if.addr_err !== 1'b0 || u_if.r_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b r_valid=%b drop=%b aerr=%b r_data=%h, expected 1 0 0 0 0",
               u_if.busy, u_if.r_valid, u_if.req_dropped, u_if.addr_err, u_if.r_data);
    end
    checks++;
    if (u_if.rd_count !== 16'd0 || u_if.wr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: rd=%0d wr=%0d, expected 0 0", u_if.rd_count, u_if.wr_count);
    end
    release_and_sweep(cnt);
    checks++;
    if (cnt != 200 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_busy: busy cycles=%0d busy_now=%b, expected 200 0", cnt, u_if.busy);
    end
    u_if.read = 1'b1; u_if.r_addr = 8'd5;
    tick();
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'h0) begin
      errors++;
      $display("FAIL clear_addr5: r_valid=%b r_data=%h, expected 1 0", u_if.r_valid, u_if.r_data);
    end
    u_if.r_addr = 8'd199;
    tick();
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'h0) begin
      errors++;
      $display("FAIL clear_addr199: r_valid=%b r_data=%h, expected 1 0", u_if.r_valid, u_if.r_data);
    end
    idle();
  endtask

  task automatic test_write_read();
    do_reset();
    u_if.write = 1'b1; u_if.w_addr = 8'd10; u_if.w_data = 64'h0000_0003_0000_0005;
    tick();
    u_if.write = 1'b0;
    u_if.read = 1'b1; u_if.r_addr = 8'd10;
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'h0000_0003_0000_0005) begin
      errors++;
      $display("FAIL wr_rd_data: r_valid=%b r_data=%h, expected 1 0000000300000005",
               u_if.r_valid, u_if.r_data);
    end
    checks++;
    if (u_if.wr_count !== 16'd1 || u_if.rd_count !== 16'd1) begin
      errors++;
      $display("FAIL wr_rd_counts: wr=%0d rd=%0d, expected 1 1", u_if.wr_count, u_if.rd_count);
    end
    tick();
    checks++;
    if (u_if.r_valid !== 1'b0 || u_if.r_data !== 64'h0000_0003_0000_0005) begin
      errors++;
      $display("FAIL rdata_hold: r_valid=%b r_data=%h, expected 0 0000000300000005",
               u_if.r_valid, u_if.r_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp [3];
    exp[0] = 64'h1111_2222_3333_4444;
    exp[1] = 64'h5555_6666_7777_8888;
    exp[2] = 64'h9999_AAAA_BBBB_CCCC;
    for (int i = 0; i < 3; i++) begin
      u_if.write = 1'b1; u_if.w_addr = 8'(30 + i); u_if.w_data = exp[i];
      tick();
    end
    u_if.write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u_if.read = 1'b1; u_if.r_addr = 8'(30 + i);
      tick();
      checks++;
      if (u_if.r_valid !== 1'b1 || u_if.r_data !== exp[i]) begin
        errors++;
        $display("FAIL b2b_read%0d: r_valid=%b r_data=%h, expected 1 %h", i, u_if.r_valid, u_if.r_data, exp[i]);
      end
    end
    // Read one address while writing another in the same cycle
    u_if.r_addr = 8'd30;
    u_if.write = 1'b1; u_if.w_addr = 8'd40; u_if.w_data = 64'hDEAD_BEEF_0000_0040;
    tick();
    u_if.write = 1'b0;
    checks++;
    if (u_if.r_data !== exp[0]) begin
      errors++;
      $display("FAIL diff_addr_rd: r_data=%h, expected %h", u_if.r_data, exp[0]);
    end
    u_if.r_addr = 8'd40;
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.r_data !== 64'hDEAD_BEEF_0000_0040 || u_if.wr_count !== 16'd5 || u_if.rd_count !== 16'd6) begin
      errors++;
      $display("FAIL diff_addr_wr: r_data=%h wr=%0d rd=%0d, expected deadbeef00000040 5 6",
               u_if.r_data, u_if.wr_count, u_if.rd_count);
    end
  endtask

  task automatic test_collision();
    u_if.write = 1'b1; u_if.w_addr = 8'd20; u_if.w_data = 64'hAAAA;
    tick();
    u_if.w_data = 64'hBBBB;
    u_if.read = 1'b1; u_if.r_addr = 8'd20;
    tick();
    u_if.write = 1'b0;
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'hAAAA) begin
      errors++;
      $display("FAIL collide_old: r_valid=%b r_data=%h, expected 1 aaaa", u_if.r_valid, u_if.r_data);
    end
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.r_data !== 64'hBBBB) begin
      errors++;
      $display("FAIL collide_new: r_data=%h, expected bbbb", u_if.r_data);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    checks++;
    if (u_if.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL aerr_clear: addr_err=%b, expected 0", u_if.addr_err);
    end
    u_if.write = 1'b1; u_if.w_addr = 8'd250; u_if.w_data = 64'h1234;
    tick();
    u_if.write = 1'b0;
    checks++;
    if (u_if.addr_err !== 1'b1) begin
      errors++;
      $display("FAIL aerr_set: addr_err=%b, expected 1", u_if.addr_err);
    end
    u_if.read = 1'b1; u_if.r_addr = 8'd250;
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'h0 || u_if.addr_err !== 1'b1 ||
        u_if.wr_count !== 16'd1 || u_if.rd_count !== 16'd1) begin
      errors++;
      $display("FAIL oob_read: r_valid=%b r_data=%h aerr=%b wr=%0d rd=%0d, expected 1 0 1 1 1",
               u_if.r_valid, u_if.r_data, u_if.addr_err, u_if.wr_count, u_if.rd_count);
    end
    // Boundary: 199 is last valid word, 200 is first invalid
    u_if.write = 1'b1; u_if.w_addr = 8'd199; u_if.w_data = 64'h77;
    tick();
    u_if.w_addr = 8'd200; u_if.w_data = 64'h88;
    u_if.read = 1'b1; u_if.r_addr = 8'd199;
    tick();
    u_if.write = 1'b0;
    checks++;
    if (u_if.r_data !== 64'h77) begin
      errors++;
      $display("FAIL edge_199: r_data=%h, expected 77", u_if.r_data);
    end
    u_if.r_addr = 8'd200;
    tick();
    u_if.r_addr = 8'd199;
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'h0) begin
      errors++;
      $display("FAIL edge_200: r_valid=%b r_data=%h, expected 1 0", u_if.r_valid, u_if.r_data);
    end
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.r_data !== 64'h77 || u_if.addr_err !== 1'b1) begin
      errors++;
      $display("FAIL edge_199_kept: r_data=%h aerr=%b, expected 77 1", u_if.r_data, u_if.addr_err);
    end
  endtask

  task automatic test_busy_drop();
    int cnt;
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    u_if.read = 1'b1; u_if.r_addr = 8'd3;
    u_if.write = 1'b1; u_if.w_addr = 8'd3; u_if.w_data = 64'hDEAD;
    tick();
    idle();
    checks++;
    if (u_if.r_valid !== 1'b0 || u_if.req_dropped !== 1'b1 || u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: r_valid=%b drop=%b busy=%b, expected 0 1 1",
               u_if.r_valid, u_if.req_dropped, u_if.busy);
    end
    tick();
    checks++;
    if (u_if.req_dropped !== 1'b0 || u_if.rd_count !== 16'd0 || u_if.wr_count !== 16'd0 ||
        u_if.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_after: drop=%b rd=%0d wr=%0d aerr=%b, expected 0 0 0 0",
               u_if.req_dropped, u_if.rd_count, u_if.wr_count, u_if.addr_err);
    end
    cnt = 0;
    while (u_if.busy === 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != 196) begin
      errors++;
      $display("FAIL drop_sweep_len: remaining busy=%0d, expected 196", cnt);
    end
    u_if.read = 1'b1; u_if.r_addr = 8'd3;
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'h0) begin
      errors++;
      $display("FAIL drop_addr3: r_valid=%b r_data=%h, expected 1 0", u_if.r_valid, u_if.r_data);
    end
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    u_if.write = 1'b1; u_if.w_addr = 8'd7; u_if.w_data = 64'hFF;
    tick();
    u_if.write = 1'b0;
    u_if.read = 1'b1; u_if.r_addr = 8'd7;
    tick();
    u_if.r_addr = 8'd255;
    tick();
    checks++;
    if (u_if.r_data !== 64'h0 || u_if.addr_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: r_data=%h aerr=%b, expected 0 1", u_if.r_data, u_if.addr_err);
    end
    u_if.r_addr = 8'd7;
    rst_ni = 1'b0;
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.busy !== 1'b1 || u_if.r_valid !== 1'b0 || u_if.addr_err !== 1'b0 ||
        u_if.rd_count !== 16'd0 || u_if.wr_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b r_valid=%b aerr=%b rd=%0d wr=%0d, expected 1 0 0 0 0",
               u_if.busy, u_if.r_valid, u_if.addr_err, u_if.rd_count, u_if.wr_count);
    end
    release_and_sweep(cnt);
    checks++;
    if (cnt != 200) begin
      errors++;
      $display("FAIL mid_sweep_len: got %0d, expected 200", cnt);
    end
    u_if.read = 1'b1; u_if.r_addr = 8'd7;
    tick();
    u_if.read = 1'b0;
    checks++;
    if (u_if.r_valid !== 1'b1 || u_if.r_data !== 64'h0 || u_if.rd_count !== 16'd1 ||
        u_if.wr_count !== 16'd0 || u_if.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_addr7: r_valid=%b r_data=%h rd=%0d wr=%0d aerr=%b, expected 1 0 1 0 0",
               u_if.r_valid, u_if.r_data, u_if.rd_count, u_if.wr_count, u_if.addr_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    u_if.read = 1'b1;  u_if.r_addr = 8'd0;
    u_if.write = 1'b1; u_if.w_addr = 8'd1; u_if.w_data = 64'h1;
    for (int i = 0; i < 65535; i++) tick();
    checks++;
    if (u_if.rd_count !== 16'hFFFF || u_if.wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: rd=%h wr=%h, expected ffff ffff", u_if.rd_count, u_if.wr_count);
    end
    tick();
    tick();
    idle();
    checks++;
    if (u_if.rd_count !== 16'hFFFF || u_if.wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: rd=%h wr=%h, expected ffff ffff", u_if.rd_count, u_if.wr_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_busy_drop();
    test_reset_mid_op();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
